// File: rtl/sdram_port_arbiter.sv
// Three-way arbiter for the single SDRAM controller port: download writes,
// video fetch reads and Z80 accesses, one at a time, with starvation and timeout guards.
module sdram_port_arbiter #(
    parameter int unsigned AW           = 23,
    parameter int unsigned DW           = 8,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          dl_req,
    input  logic [AW-1:0] dl_addr,
    input  logic [DW-1:0] dl_din,
    output logic          dl_ack,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_dout,
    output logic          vid_ack,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    input  logic          mem_ack,
    output logic [1:0]    grant,
    output logic          timeout_err
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_DL   = 2'd1;
    localparam logic [1:0] G_VID  = 2'd2;
    localparam logic [1:0] G_CPU  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [SW-1:0]   starve;
    logic [7:0]      tcnt;
    logic [1:0]      win_c;

    // Fixed priority, except a CPU that has lost STARVE_LIMIT times in a row beats video
    always_comb begin
        win_c = G_NONE;
        if (dl_req)
            win_c = G_DL;
        else if (cpu_req && (starve == STARVE_MAX))
            win_c = G_CPU;
        else if (vid_req)
            win_c = G_VID;
        else if (cpu_req)
            win_c = G_CPU;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            grant       <= G_NONE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            dl_ack      <= 1'b0;
            vid_ack     <= 1'b0;
            cpu_ack     <= 1'b0;
            vid_dout    <= '0;
            cpu_dout    <= '0;
            timeout_err <= 1'b0;
            starve      <= '0;
            tcnt        <= '0;
        end else begin
            dl_ack      <= 1'b0;
            vid_ack     <= 1'b0;
            cpu_ack     <= 1'b0;
            timeout_err <= 1'b0;

            case (state)
                S_IDLE: begin
                    grant <= win_c;
                    if (!cpu_req || (win_c == G_CPU))
                        starve <= '0;
                    else if (starve != STARVE_MAX)
                        starve <= starve + SW'(1);

                    if (win_c != G_NONE) begin
                        state   <= S_ISSUE;
                        mem_req <= 1'b1;
                        tcnt    <= '0;
                        case (win_c)
                            G_DL: begin
                                mem_we   <= 1'b1;
                                mem_addr <= dl_addr;
                                mem_din  <= dl_din;
                            end
                            G_VID: begin
                                mem_we   <= 1'b0;
                                mem_addr <= vid_addr;
                            end
                            default: begin
                                mem_we   <= cpu_we;
                                mem_addr <= cpu_addr;
                                mem_din  <= cpu_din;
                            end
                        endcase
                    end
                end

                // An ack on the limit cycle wins over the abort
                S_ISSUE: begin
                    if (mem_ack || (tcnt == TO_LAST)) begin
                        state       <= S_DONE;
                        mem_req     <= 1'b0;
                        timeout_err <= !mem_ack;
                        case (grant)
                            G_DL: dl_ack <= 1'b1;
                            G_VID: begin
                                vid_ack  <= 1'b1;
                                vid_dout <= mem_ack ? mem_dout : {DW{1'b1}};
                            end
                            G_CPU: begin
                                cpu_ack <= 1'b1;
                                if (!mem_ack)
                                    cpu_dout <= {DW{1'b1}};
                                else if (!mem_we)
                                    cpu_dout <= mem_dout;
                            end
                            default: ;
                        endcase
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    grant <= G_NONE;
                end

                default: begin
                    state   <= S_IDLE;
                    grant   <= G_NONE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: a scripted SDRAM responder, an access log
// and hand-computed expectations for priority, starvation, timeout and reset behaviour.
module tb_sdram_port_arbiter;

    localparam int unsigned AW = 23;
    localparam int unsigned DW = 8;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          dl_req = 1'b0, vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] dl_addr = '0, vid_addr = '0, cpu_addr = '0;
    logic [DW-1:0] dl_din = '0, cpu_din = '0;
    logic          dl_ack, vid_ack, cpu_ack;
    logic [DW-1:0] vid_dout, cpu_dout;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout = '0;
    logic          mem_ack = 1'b0;
    logic [1:0]    grant;
    logic          timeout_err;
    logic [2:0]    acks;

    assign acks = {dl_ack, vid_ack, cpu_ack};

    always #5 clk_sys = ~clk_sys;

    sdram_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4), .TIMEOUT(255)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .dl_req(dl_req), .dl_addr(dl_addr), .dl_din(dl_din), .dl_ack(dl_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_ack(vid_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_ack(mem_ack),
        .grant(grant), .timeout_err(timeout_err)
    );

    int         n_vec = 0;
    int         n_bad = 0;
    int         ack_delay = 0;     // ISSUE cycles before mem_ack; negative = never
    logic [7:0] rdata = 8'h00;
    logic       force_ack = 1'b0;  // drives mem_ack while no request is pending
    int         rcnt = 0;

    // Scripted controller: acks ack_delay cycles after mem_req rises
    always @(negedge clk_sys) begin
        mem_dout = rdata;
        if (!mem_req) begin
            rcnt    = 0;
            mem_ack = force_ack;
        end else begin
            mem_ack = (ack_delay >= 0) && (rcnt == ack_delay);
            rcnt++;
        end
    end

    typedef struct packed {
        logic [1:0]    g;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } acc_t;

    acc_t       log_q[$];
    logic [1:0] prev_g = 2'd0;

    always @(negedge clk_sys) begin
        if (grant != 2'd0 && prev_g == 2'd0)
            log_q.push_back(acc_t'{grant, mem_we, mem_addr, mem_din});
        prev_g = grant;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #2;
    endtask

    // Plays the requesters: drop each req once its ack is seen
    task automatic serve(input int maxc, input bit keep_vid, output int n);
        n = 0;
        while ((dl_req || vid_req || cpu_req) && n < maxc) begin
            tick();
            n++;
            if (dl_ack) dl_req = 1'b0;
            if (vid_ack && !keep_vid) vid_req = 1'b0;
            if (cpu_ack) cpu_req = 1'b0;
        end
        chk("serve_pending", 32'({dl_req, vid_req, cpu_req}), 32'd0);
    endtask

    initial begin
        int         n;
        logic [2:0] seen;
        logic       req255;
        logic [1:0] exp_g [10];

        // Reset state
        #17;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_acks", 32'(acks), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Single CPU read, mem_ack in the second ISSUE cycle
        ack_delay = 1;
        rdata     = 8'h5A;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 23'h000100;
        tick();
        chk("rd_grant", 32'(grant), 32'd3);
        chk("rd_mem_req", 32'(mem_req), 32'd1);
        chk("rd_mem_addr", 32'(mem_addr), 32'h100);
        chk("rd_mem_we", 32'(mem_we), 32'd0);
        tick();
        chk("rd_early_ack", 32'(acks), 32'd0);
        tick();
        chk("rd_ack", 32'(acks), 32'b001);
        chk("rd_dout", 32'(cpu_dout), 32'h5A);
        chk("rd_grant_done", 32'(grant), 32'd3);
        chk("rd_req_done", 32'(mem_req), 32'd0);
        cpu_req = 1'b0;
        tick();
        chk("rd_ack_once", 32'(acks), 32'd0);
        chk("rd_grant_idle", 32'(grant), 32'd0);

        // All three at once: dl, vid, cpu-write in that order, 3 cycles each
        ack_delay = 0;
        rdata     = 8'h33;
        log_q.delete();
        dl_req  = 1'b1; dl_addr  = 23'h0ABCDE; dl_din = 8'hA5;
        vid_req = 1'b1; vid_addr = 23'h002000;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 23'h000300; cpu_din = 8'hC3;
        serve(40, 1'b0, n);
        chk("pri_cycles", 32'(n), 32'd8);
        chk("pri_count", 32'(log_q.size()), 32'd3);
        if (log_q.size() >= 3) begin
            chk("pri_g0", 32'(log_q[0].g), 32'd1);
            chk("pri_dl_we", 32'(log_q[0].we), 32'd1);
            chk("pri_dl_addr", 32'(log_q[0].a), 32'h0ABCDE);
            chk("pri_dl_din", 32'(log_q[0].d), 32'hA5);
            chk("pri_g1", 32'(log_q[1].g), 32'd2);
            chk("pri_vid_we", 32'(log_q[1].we), 32'd0);
            chk("pri_vid_addr", 32'(log_q[1].a), 32'h002000);
            chk("pri_g2", 32'(log_q[2].g), 32'd3);
            chk("pri_cpu_we", 32'(log_q[2].we), 32'd1);
            chk("pri_cpu_din", 32'(log_q[2].d), 32'hC3);
        end
        chk("pri_vid_dout", 32'(vid_dout), 32'h33);
        chk("pri_cpu_dout_kept", 32'(cpu_dout), 32'h5A);
        tick();

        // Video held continuously with a waiting CPU: every fifth grant goes to the CPU
        log_q.delete();
        cpu_we  = 1'b0;
        vid_req = 1'b1;
        cpu_req = 1'b1;
        for (int i = 0; i < 32; i++) tick();
        vid_req = 1'b0;
        cpu_req = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        exp_g = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
        chk("starve_count_ge10", 32'(log_q.size() >= 10), 32'd1);
        for (int i = 0; i < 10 && i < log_q.size(); i++)
            chk($sformatf("starve_g%0d", i), 32'(log_q[i].g), 32'(exp_g[i]));
        chk("starve_idle", 32'(grant), 32'd0);

        // Hung controller: abort after 255 ISSUE cycles
        ack_delay = -1;
        cpu_req   = 1'b1;
        cpu_addr  = 23'h7FFFFF;
        n         = 0;
        req255    = 1'b0;
        while (!cpu_ack && n < 300) begin
            tick();
            n++;
            if (n == 255) req255 = mem_req;
        end
        chk("to_cycles", 32'(n), 32'd256);
        chk("to_req_held", 32'(req255), 32'd1);
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_dout", 32'(cpu_dout), 32'hFF);
        chk("to_mem_req", 32'(mem_req), 32'd0);
        cpu_req = 1'b0;
        tick();
        chk("to_err_pulse", 32'(timeout_err), 32'd0);
        chk("to_idle", 32'(grant), 32'd0);

        // Stray mem_ack while idle
        force_ack = 1'b1;
        seen      = 3'b000;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen |= acks;
        end
        force_ack = 1'b0;
        chk("stray_acks", 32'(seen), 32'd0);
        chk("stray_grant", 32'(grant), 32'd0);

        // Video request toggled mid-access is ignored
        ack_delay = 3;
        rdata     = 8'h6C;
        vid_req   = 1'b1;
        vid_addr  = 23'h001234;
        tick();
        chk("tog_grant", 32'(grant), 32'd2);
        vid_req  = 1'b0;
        vid_addr = 23'h000999;
        tick();
        chk("tog_grant_held", 32'(grant), 32'd2);
        chk("tog_addr_held", 32'(mem_addr), 32'h001234);
        chk("tog_req_held", 32'(mem_req), 32'd1);
        vid_req = 1'b1;
        n       = 2;
        while (!vid_ack && n < 20) begin
            tick();
            n++;
        end
        chk("tog_ack_cycle", 32'(n), 32'd5);
        chk("tog_vid_dout", 32'(vid_dout), 32'h6C);
        chk("tog_cpu_dout_kept", 32'(cpu_dout), 32'hFF);
        vid_req = 1'b0;
        tick();
        chk("tog_idle", 32'(grant), 32'd0);

        // Reset in the middle of an access
        ack_delay = -1;
        cpu_req   = 1'b1;
        cpu_addr  = 23'h000040;
        tick();
        tick();
        chk("mid_req", 32'(mem_req), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_dout", 32'(cpu_dout), 32'd0);
        cpu_req = 1'b0;
        tick();
        reset_n = 1'b1;
        seen    = 3'b000;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen |= {acks[2:1], acks[0] | timeout_err};
        end
        chk("mid_no_ack", 32'(seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
